io_clk_config_arbiter: RTL and testbench

IO_CLK_CONFIG_ARBITER -- requirements
Module: io_clk_config_arbiter

---
 rtl/io_clk_config_arbiter.sv | 118 +++++++++++
 tb/tb_io_clk_config_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_clk_config_arbiter.sv
// Round-robin arbiter serialising requester reads/writes onto the clock-generator
// config port, with a post-write settle hold-off before the completion pulse.
module io_clk_config_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   sys_clk,
  input  logic                   sync_rst,
  input  logic                   clk_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [2*NUM_REQ-1:0]   req_addr,
  input  logic [2*NUM_REQ-1:0]   req_half_en,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_data,
  output logic                   busy,
  output logic [1:0]             cfg_addr,
  output logic                   cfg_we_upper,
  output logic                   cfg_we_lower,
  output logic [15:0]            cfg_wdata,
  input  logic [15:0]            cfg_rdata,
  output logic [1:0]             dbg_state
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_t;

  state_t           state, state_next;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] last_grant, owner, grant_idx, cand_idx;
  logic             grant_found, accept, issue_on;
  logic             lat_write;
  logic [1:0]       lat_half;

  logic [1:0]  addr_arr [NUM_REQ];
  logic [1:0]  half_arr [NUM_REQ];
  logic [15:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[2*g +: 2];
    assign half_arr[g] = req_half_en[2*g +: 2];
    assign data_arr[g] = req_data[16*g +: 16];
  end

  // Handshake: a requester holds req_valid and payload stable until it sees
  // req_ready high for one cycle; that cycle's rising edge is the transfer.
  // Dropping req_valid earlier withdraws the request without side effects.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign accept   = sync_rst && clk_en && grant_found && (state == IDLE || state == RESP);
  assign issue_on = sync_rst && clk_en && (state == ISSUE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = (lat_write && (SETTLE_CYCLES > 0)) ? SETTLE : RESP;
      SETTLE:  if (cnt == 8'd0) state_next = RESP;
      RESP:    state_next = accept ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready    = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid    = (sync_rst && clk_en && state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign cfg_we_upper = issue_on && lat_write && lat_half[1];
  assign cfg_we_lower = issue_on && lat_write && lat_half[0];
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

  always_ff @(posedge sys_clk) begin
    if (!sync_rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_grant <= LAST_RST;
      owner      <= '0;
      lat_write  <= 1'b0;
      lat_half   <= 2'b00;
      cfg_addr   <= 2'd0;
      cfg_wdata  <= 16'd0;
      rsp_data   <= 16'd0;
    end else if (clk_en) begin
      state <= state_next;
      if (accept) begin
        owner      <= grant_idx;
        last_grant <= grant_idx;
        // A write with no byte enables behaves exactly like a read.
        lat_write  <= req_write[grant_idx] && (half_arr[grant_idx] != 2'b00);
        lat_half   <= half_arr[grant_idx];
        cfg_addr   <= addr_arr[grant_idx];
        cfg_wdata  <= data_arr[grant_idx];
      end
      if (state == ISSUE) begin
        rsp_data <= cfg_rdata;
        cnt      <= SETTLE_LOAD;
      end else if (state == SETTLE && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_io_clk_config_arbiter.sv
// Directed and randomized bench for io_clk_config_arbiter against a
// transaction-level model of grant order, config slots and completion latency.
module tb_io_clk_config_arbiter;

  localparam int N = 4;
  localparam int S = 4;

  logic              sys_clk = 1'b0;
  logic              sync_rst;
  logic              clk_en;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [2*N-1:0]    req_addr, req_half_en;
  logic [16*N-1:0]   req_data;
  logic [15:0]       rsp_data, cfg_wdata, cfg_rdata;
  logic              busy, cfg_we_upper, cfg_we_lower;
  logic [1:0]        cfg_addr, dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] cfg_mem   [4];
  logic [15:0] model_mem [4];
  logic        env_init;
  int          model_last;
  logic [15:0] exp_q[$];

  io_clk_config_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
    .sys_clk      (sys_clk),
    .sync_rst     (sync_rst),
    .clk_en       (clk_en),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_half_en  (req_half_en),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .cfg_addr     (cfg_addr),
    .cfg_we_upper (cfg_we_upper),
    .cfg_we_lower (cfg_we_lower),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .dbg_state    (dbg_state)
  );

  // Clock and the clock-generator config register file seen by the DUT.
  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] init_val(input int k);
    return (k == 3) ? 16'hBEEF : 16'(16'h1111 * (k + 1));
  endfunction

  assign cfg_rdata = cfg_mem[cfg_addr];

  always @(posedge sys_clk) begin
    if (env_init) begin
      for (int k = 0; k < 4; k++) cfg_mem[k] <= init_val(k);
    end else begin
      if (cfg_we_upper) cfg_mem[cfg_addr][15:8] <= cfg_wdata[15:8];
      if (cfg_we_lower) cfg_mem[cfg_addr][7:0]  <= cfg_wdata[7:0];
    end
  end

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  // Round-robin rule: first valid requester after the last winner.
  function automatic int model_pick(input logic [N-1:0] v);
    logic [N-1:0] sh;
    for (int k = 1; k <= N; k++) begin
      sh = v >> ((model_last + k) % N);
      if (sh[0]) return (model_last + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_req(input int idx, input logic w, input logic [1:0] a,
                           input logic [1:0] h, input logic [15:0] d);
    req_valid   = N'(1) << idx;
    req_write   = N'(w) << idx;
    req_addr    = (2*N)'(a) << (2*idx);
    req_half_en = (2*N)'(h) << (2*idx);
    req_data    = (16*N)'(d) << (16*idx);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sync_rst = 1'b0;
    @(negedge sys_clk);
    sync_rst = 1'b1;
    model_last = N - 1;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    check(tag, busy, 0);
  endtask

  // One transaction from a single requester; freeze_at>0 drops clk_en for
  // three cycles starting that many cycles after the accept cycle.
  task automatic run_txn(input string tag, input int idx, input logic w, input logic [1:0] a,
                         input logic [1:0] h, input logic [15:0] d, input int freeze_at);
    int n, strobes, exp_lat, pick;
    logic eff;
    logic [15:0] exp_data;
    eff     = w && (h != 2'b00);
    exp_lat = (eff ? 2 + S : 2) + ((freeze_at > 0) ? 3 : 0);
    @(negedge sys_clk);
    apply_req(idx, w, a, h, d);
    pick = model_pick(oh(idx));
    n = 0;
    #1;
    while (req_ready == '0 && n < 10) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    check({tag, "_ready"}, req_ready, oh(pick));
    model_last = pick;
    exp_q.push_back(model_mem[a]);
    if (w && h[1]) model_mem[a][15:8] = d[15:8];
    if (w && h[0]) model_mem[a][7:0]  = d[7:0];
    @(negedge sys_clk);
    req_valid = '0;
    #1;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_cfg_addr"}, cfg_addr, a);
    check({tag, "_cfg_wdata"}, cfg_wdata, d);
    check({tag, "_we_upper"}, cfg_we_upper, w & h[1]);
    check({tag, "_we_lower"}, cfg_we_lower, w & h[0]);
    n = 1;
    strobes = 0;
    while (n < 40) begin
      @(negedge sys_clk);
      n++;
      clk_en = !(freeze_at > 0 && n >= freeze_at && n < freeze_at + 3);
      #1;
      if (cfg_we_upper || cfg_we_lower) strobes++;
      if (rsp_valid != '0) break;
    end
    clk_en = 1'b1;
    exp_data = exp_q.pop_front();
    check({tag, "_rsp_lat"}, n, exp_lat);
    check({tag, "_rsp_owner"}, rsp_valid, oh(idx));
    check({tag, "_rsp_data"}, rsp_data, exp_data);
    check({tag, "_late_strobe"}, strobes, 0);
  endtask

  initial begin
    int got, cyc, pick, cnt_rsp, fz, idx;
    logic w;
    logic [1:0] a, h;
    logic [15:0] d;

    sync_rst = 1'b0;
    clk_en = 1'b1;
    env_init = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_half_en = '0; req_data = '0;
    for (int k = 0; k < 4; k++) model_mem[k] = init_val(k);
    model_last = N - 1;
    repeat (2) @(negedge sys_clk);
    env_init = 1'b0;
    sync_rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_cfg_addr", cfg_addr, 0);
    check("rst_cfg_wdata", cfg_wdata, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_strobes", {cfg_we_upper, cfg_we_lower}, 0);

    // Directed paths: full write, read, half write, empty write, readback, freeze.
    run_txn("w_full", 0, 1'b1, 2'd2, 2'b11, 16'h1A05, 0);
    run_txn("r_slot3", 1, 1'b0, 2'd3, 2'b00, 16'h0000, 0);
    run_txn("w_lo", 2, 1'b1, 2'd1, 2'b01, 16'hA5C3, 0);
    run_txn("w_none", 3, 1'b1, 2'd0, 2'b00, 16'hFFFF, 0);
    run_txn("r_back", 0, 1'b0, 2'd1, 2'b10, 16'h0000, 0);
    run_txn("w_freeze", 1, 1'b1, 2'd0, 2'b11, 16'h5AA5, 3);

    // Fairness: all requesters valid straight after reset.
    do_reset();
    req_valid = '1; req_write = '0; req_addr = 8'b11_10_01_00; req_half_en = '0;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 60) begin
      #1;
      if (req_ready != '0) begin
        pick = model_pick('1);
        check("fair_grant", req_ready, oh(pick));
        model_last = pick;
        got++;
      end
      cyc++;
      @(negedge sys_clk);
    end
    req_valid = '0;
    check("fair_count", got, 5);
    wait_idle("fair_idle");

    // Reset while in SETTLE abandons the write and restarts arbitration at 0.
    @(negedge sys_clk);
    apply_req(2, 1'b1, 2'd1, 2'b11, 16'h7E81);
    pick = model_pick(oh(2));
    #1;
    check("abort_ready", req_ready, oh(pick));
    model_last = pick;
    model_mem[1] = 16'h7E81;
    @(negedge sys_clk);
    req_valid = '0;
    #1;
    check("abort_issue_we", cfg_we_upper & cfg_we_lower, 1);
    repeat (2) @(negedge sys_clk);
    #1;
    check("abort_busy_pre", busy, 1);
    sync_rst = 1'b0;
    @(negedge sys_clk);
    sync_rst = 1'b1;
    model_last = N - 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    cnt_rsp = 0;
    repeat (8) begin
      @(negedge sys_clk);
      #1;
      if (rsp_valid != '0) cnt_rsp++;
    end
    check("abort_no_rsp", cnt_rsp, 0);
    @(negedge sys_clk);
    req_valid = '1; req_write = '0; req_half_en = '0;
    #1;
    check("abort_next_grant", req_ready, oh(model_pick('1)));
    model_last = model_pick('1);
    @(negedge sys_clk);
    req_valid = '0;
    wait_idle("abort_idle");

    // Randomized single transactions, some with a freeze window.
    for (int t = 0; t < 24; t++) begin
      idx = $urandom_range(0, N - 1);
      w   = 1'($urandom_range(0, 1));
      a   = 2'($urandom_range(0, 3));
      h   = 2'($urandom_range(0, 3));
      d   = 16'($urandom);
      fz  = ($urandom_range(0, 3) == 0) ? 2 : 0;
      run_txn("rand", idx, w, a, h, d, fz);
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
